// File: rtl/commit_rob.sv
// commit_rob -- in-order reorder buffer between issue and commit.
//
// Allocates one slot per issued instruction (slot index == transaction ID),
// collects functional-unit writebacks by transaction ID and presents the
// oldest NrCommitPorts entries to the commit stage, retiring them on ack.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              discard every entry (synchronous, highest priority)
//   issue_instr_i        entry to allocate
//   issue_valid_i        allocation request
//   issue_ready_o        a slot is free
//   issue_trans_id_o     slot the current request will receive (tail)
//   wb_valid_i           per-port writeback strobe
//   wb_trans_id_i        target slot of each writeback
//   wb_result_i          writeback result
//   wb_ex_i              writeback exception
//   commit_instr_o       oldest entries in program order
//   commit_ack_i         retire the presented entries (leading ones count)
//   empty_o              buffer holds no entries

package commit_rob_pkg;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t CVA6_CFG_DEFAULT = '{NrCommitPorts: 32'd2};

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          pc;
    logic [7:0]               op;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module commit_rob
  import commit_rob_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg     = CVA6_CFG_DEFAULT,
  parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  scoreboard_entry_t                           issue_instr_i,
  input  logic                                        issue_valid_i,
  output logic                                        issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]                wb_ex_i,
  output scoreboard_entry_t [CVA6Cfg.NrCommitPorts-1:0] commit_instr_o,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]            commit_ack_i,
  output logic                                        empty_o
);

  localparam int unsigned NCP = CVA6Cfg.NrCommitPorts;
  localparam int unsigned IDW = TRANS_ID_BITS;

  localparam logic [IDW:0]   FULL_COUNT = (IDW+1)'(NR_ENTRIES);
  localparam logic [IDW:0]   ONE_COUNT  = (IDW+1)'(1'b1);
  localparam logic [IDW-1:0] ONE_ID     = IDW'(1'b1);

  // Slot that sits `off` positions after `base`, wrapping modulo NR_ENTRIES.
  function automatic logic [IDW-1:0] slot_at(input logic [IDW-1:0] base,
                                             input int unsigned    off);
    return base + IDW'(off);
  endfunction

  scoreboard_entry_t mem_q [NR_ENTRIES];
  scoreboard_entry_t mem_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] issued_q, issued_d;
  logic [IDW-1:0]        head_q, head_d;
  logic [IDW-1:0]        tail_q, tail_d;
  logic [IDW:0]          count_q, count_d;

  scoreboard_entry_t [NCP-1:0] commit_view_s;
  logic [IDW:0]                pop_cnt_s;
  logic [NR_ENTRIES-1:0]       pop_mask_s;
  logic                        pop_run_s;
  logic                        issue_fire_s;

  // Status outputs are pure functions of registered state.
  assign issue_ready_o    = (count_q != FULL_COUNT);
  assign issue_trans_id_o = tail_q;
  assign empty_o          = (count_q == '0);
  assign issue_fire_s     = issue_valid_i & issue_ready_o & ~flush_i;
  assign commit_instr_o   = commit_view_s;

  // Commit view: oldest entries, valid masked unless the slot is live and issued.
  always_comb begin
    commit_view_s = '0;
    for (int unsigned i = 0; i < NCP; i++) begin
      commit_view_s[i] = mem_q[slot_at(head_q, i)];
      if (((IDW+1)'(i) < count_q) && issued_q[slot_at(head_q, i)]) begin
        commit_view_s[i].valid = mem_q[slot_at(head_q, i)].valid;
      end else begin
        commit_view_s[i].valid = 1'b0;
      end
    end
  end

  // Retire: only a leading run of acks on valid ports pops entries.
  always_comb begin
    pop_cnt_s  = '0;
    pop_mask_s = '0;
    pop_run_s  = 1'b1;
    for (int unsigned i = 0; i < NCP; i++) begin
      if (pop_run_s && commit_ack_i[i] && commit_view_s[i].valid) begin
        pop_cnt_s                        = pop_cnt_s + ONE_COUNT;
        pop_mask_s[slot_at(head_q, i)]   = 1'b1;
      end else begin
        pop_run_s = 1'b0;
      end
    end
  end

  // Pointer, count and issued-bit next state; flush overrides everything.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    issued_d = issued_q;
    if (flush_i) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      issued_d = '0;
    end else begin
      // A popped slot can never be the tail being issued: that needs count==N,
      // where issue is stalled.
      issued_d = issued_q & ~pop_mask_s;
      if (issue_fire_s) begin
        issued_d[tail_q] = 1'b1;
        tail_d           = tail_q + ONE_ID;
      end else begin
        tail_d = tail_q;
      end
      head_d  = head_q + pop_cnt_s[IDW-1:0];
      count_d = count_q + {{IDW{1'b0}}, issue_fire_s} - pop_cnt_s;
    end
  end

  // Entry storage next state: writebacks (highest port last so it wins), then issue.
  always_comb begin
    mem_d = mem_q;
    if (!flush_i) begin
      for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && issued_q[wb_trans_id_i[p]]) begin
          mem_d[wb_trans_id_i[p]].valid  = 1'b1;
          mem_d[wb_trans_id_i[p]].result = wb_result_i[p];
          if (wb_ex_i[p].valid) begin
            mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
          end else begin
            mem_d[wb_trans_id_i[p]].ex = mem_d[wb_trans_id_i[p]].ex;
          end
        end else begin
          mem_d[wb_trans_id_i[p]] = mem_d[wb_trans_id_i[p]];
        end
      end
      // The tail slot is never issued while issue can fire, so no writeback
      // above can have touched it.
      if (issue_fire_s) begin
        mem_d[tail_q]          = issue_instr_i;
        mem_d[tail_q].trans_id = tail_q;
        mem_d[tail_q].valid    = issue_instr_i.ex.valid;
      end else begin
        mem_d[tail_q] = mem_d[tail_q];
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      issued_q <= issued_d;
    end
  end

  // Entry storage; contents are only meaningful where the issued bit is set.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_commit_rob.sv
module tb_commit_rob;
  import commit_rob_pkg::*;

  localparam int NCP = 2;
  localparam int NWB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                          flush;
  scoreboard_entry_t             issue_instr;
  logic                          issue_valid;
  logic                          issue_ready;
  logic [TRANS_ID_BITS-1:0]      issue_trans_id;
  logic [NWB-1:0]                wb_valid;
  logic [NWB-1:0][TRANS_ID_BITS-1:0] wb_trans_id;
  logic [NWB-1:0][XLEN-1:0]      wb_result;
  exception_t [NWB-1:0]          wb_ex;
  scoreboard_entry_t [NCP-1:0]   commit_instr;
  logic [NCP-1:0]                commit_ack;
  logic                          empty;

  commit_rob #(
    .CVA6Cfg    (CVA6_CFG_DEFAULT),
    .NR_ENTRIES (8),
    .NR_WB_PORTS(NWB)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .issue_instr_i   (issue_instr),
    .issue_valid_i   (issue_valid),
    .issue_ready_o   (issue_ready),
    .issue_trans_id_o(issue_trans_id),
    .wb_valid_i      (wb_valid),
    .wb_trans_id_i   (wb_trans_id),
    .wb_result_i     (wb_result),
    .wb_ex_i         (wb_ex),
    .commit_instr_o  (commit_instr),
    .commit_ack_i    (commit_ack),
    .empty_o         (empty)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] res;
    logic        is_ex;
    logic [31:0] cause;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [31:0] res,
                          input logic is_ex, input logic [31:0] cause);
    exp_t e;
    e.id = id; e.res = res; e.is_ex = is_ex; e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic clear_in();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_instr = '0;
    wb_valid    = '0;
    wb_trans_id = '0;
    wb_result   = '0;
    wb_ex       = '0;
    commit_ack  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic set_issue(input logic [31:0] pc, input logic exv, input logic [31:0] cause);
    issue_valid        = 1'b1;
    issue_instr        = '0;
    issue_instr.pc     = pc;
    issue_instr.ex.valid = exv;
    issue_instr.ex.cause = cause;
  endtask

  task automatic set_wb(input int port, input logic [2:0] id, input logic [31:0] res);
    wb_valid[port]    = 1'b1;
    wb_trans_id[port] = id;
    wb_result[port]   = res;
  endtask

  // Retire monitor: mid-cycle, every leading ack on a valid port is a retirement.
  logic mon_run;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon_run = 1'b1;
        for (int i = 0; i < NCP; i++) begin
          if (mon_run && commit_ack[i] && commit_instr[i].valid) begin
            if (exp_q.size() == 0) begin
              n_total++;
              $display("FAIL retire_unexpected: got id %0d, expected no retirement",
                       commit_instr[i].trans_id);
            end else begin
              mon_e = exp_q.pop_front();
              check("retire_id", 32'(commit_instr[i].trans_id), 32'(mon_e.id));
              if (mon_e.is_ex) check("retire_cause", commit_instr[i].ex.cause, mon_e.cause);
              else             check("retire_result", commit_instr[i].result, mon_e.res);
            end
          end else begin
            mon_run = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_trans_id", 32'(issue_trans_id), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_p0_valid", 32'(commit_instr[0].valid), 32'd0);
    check("rst_p1_valid", 32'(commit_instr[1].valid), 32'd0);
    rst_n = 1'b1;
    step();

    // In-order retire with out-of-order writebacks.
    for (int k = 0; k < 3; k++) begin
      set_issue(32'h100 + 32'(k), 1'b0, 32'd0);
      step();
      check("t1_trans_id", 32'(issue_trans_id), 32'(k + 1));
    end
    check("t1_p0_id", 32'(commit_instr[0].trans_id), 32'd0);
    check("t1_p0_valid_before_wb", 32'(commit_instr[0].valid), 32'd0);
    set_wb(0, 3'd1, 32'h11);
    step();
    check("t1_p0_valid_after_wb1", 32'(commit_instr[0].valid), 32'd0);
    check("t1_p1_valid_after_wb1", 32'(commit_instr[1].valid), 32'd1);
    set_wb(0, 3'd0, 32'h10);
    set_wb(1, 3'd2, 32'h12);
    step();
    check("t1_p0_valid_after_wb0", 32'(commit_instr[0].valid), 32'd1);
    push_exp(3'd0, 32'h10, 1'b0, 32'd0);
    push_exp(3'd1, 32'h11, 1'b0, 32'd0);
    push_exp(3'd2, 32'h12, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      commit_ack = 2'b01;
      step();
    end
    check("t1_empty", 32'(empty), 32'd1);

    // Full buffer.
    flush = 1'b1;
    step();
    check("t2_flush_trans_id", 32'(issue_trans_id), 32'd0);
    for (int k = 0; k < 8; k++) begin
      set_issue(32'h200 + 32'(k), 1'b0, 32'd0);
      step();
    end
    check("t2_full_ready", 32'(issue_ready), 32'd0);
    check("t2_full_trans_id", 32'(issue_trans_id), 32'd0);
    check("t2_full_empty", 32'(empty), 32'd0);
    set_issue(32'hDEAD, 1'b0, 32'd0);
    step();
    check("t2_stall_trans_id", 32'(issue_trans_id), 32'd0);
    check("t2_stall_p0_pc", commit_instr[0].pc, 32'h200);
    set_wb(2, 3'd0, 32'h20);
    push_exp(3'd0, 32'h20, 1'b0, 32'd0);
    step();
    check("t2_ready_before_ack", 32'(issue_ready), 32'd0);
    commit_ack = 2'b01;
    step();
    check("t2_ready_after_retire", 32'(issue_ready), 32'd1);
    set_wb(0, 3'd1, 32'h21);
    push_exp(3'd1, 32'h21, 1'b0, 32'd0);
    step();
    set_issue(32'h300, 1'b0, 32'd0);
    commit_ack = 2'b01;
    step();
    check("t2_issue_ack_ready", 32'(issue_ready), 32'd1);
    check("t2_issue_ack_trans_id", 32'(issue_trans_id), 32'd1);
    check("t2_issue_ack_head", 32'(commit_instr[0].trans_id), 32'd2);
    set_issue(32'h301, 1'b0, 32'd0);
    step();
    check("t2_full_again", 32'(issue_ready), 32'd0);

    // Dual commit.
    flush = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      set_issue(32'h500 + 32'(k), 1'b0, 32'd0);
      step();
    end
    for (int p = 0; p < 4; p++) set_wb(p, 3'(p), 32'h30 + 32'(p));
    step();
    set_wb(0, 3'd4, 32'h34);
    step();
    for (int k = 0; k < 5; k++) push_exp(3'(k), 32'h30 + 32'(k), 1'b0, 32'd0);
    commit_ack = 2'b11;
    step();
    check("t3_head_after_dual", 32'(commit_instr[0].trans_id), 32'd2);
    commit_ack = 2'b01;
    step();
    check("t3_p0_id", 32'(commit_instr[0].trans_id), 32'd3);
    check("t3_p1_id", 32'(commit_instr[1].trans_id), 32'd4);
    check("t3_p1_valid", 32'(commit_instr[1].valid), 32'd1);
    commit_ack = 2'b10;
    step();
    check("t3_ack10_no_pop", 32'(commit_instr[0].trans_id), 32'd3);
    check("t3_ack10_not_empty", 32'(empty), 32'd0);
    commit_ack = 2'b11;
    step();
    check("t3_empty", 32'(empty), 32'd1);

    // Pre-excepted entry is committable without writeback.
    set_issue(32'h400, 1'b1, 32'd12);
    step();
    check("t4_p0_valid", 32'(commit_instr[0].valid), 32'd1);
    check("t4_p0_cause", commit_instr[0].ex.cause, 32'd12);
    check("t4_p0_id", 32'(commit_instr[0].trans_id), 32'd5);
    push_exp(3'd5, 32'd0, 1'b1, 32'd12);
    commit_ack = 2'b01;
    step();
    check("t4_empty", 32'(empty), 32'd1);

    // Flush with concurrent issue, writeback and ack.
    for (int k = 0; k < 5; k++) begin
      set_issue(32'h700 + 32'(k), 1'b0, 32'd0);
      step();
    end
    check("t5_not_empty", 32'(empty), 32'd0);
    flush = 1'b1;
    set_issue(32'h7FF, 1'b0, 32'd0);
    set_wb(0, 3'd6, 32'h66);
    commit_ack = 2'b01;
    step();
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_trans_id", 32'(issue_trans_id), 32'd0);
    check("t5_p0_valid", 32'(commit_instr[0].valid), 32'd0);
    check("t5_p1_valid", 32'(commit_instr[1].valid), 32'd0);
    check("t5_ready", 32'(issue_ready), 32'd1);
    set_wb(1, 3'd2, 32'h55);
    step();
    check("t5_late_wb_empty", 32'(empty), 32'd1);
    check("t5_late_wb_p0_valid", 32'(commit_instr[0].valid), 32'd0);

    // Same-slot writeback collision: highest port wins.
    set_issue(32'h600, 1'b0, 32'd0);
    step();
    set_wb(0, 3'd0, 32'hA);
    set_wb(3, 3'd0, 32'hB);
    step();
    check("t6_result", commit_instr[0].result, 32'hB);
    check("t6_valid", 32'(commit_instr[0].valid), 32'd1);
    push_exp(3'd0, 32'hB, 1'b0, 32'd0);
    commit_ack = 2'b01;
    step();
    check("t6_empty", 32'(empty), 32'd1);

    repeat (2) step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
